vga_timing_sequencer: RTL and testbench



---
 rtl/vga_timing_sequencer.sv | 130 +++++++++++++
 tb/tb_vga_timing_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/vga_timing_sequencer.sv
// VGA raster timing generator: pixel tick at HCLK/2, frame-buffer fetch sequencing,
// and a 2-HCLK output pipeline that keeps HSYNC, VSYNC and RGB aligned.
`timescale 1ns/1ps
module vga_timing_sequencer #(
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int ADDR_W    = 19
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              enable,
  input  logic [ADDR_W-1:0] cfg_base,
  output logic              fb_rd_en,
  output logic [ADDR_W-1:0] fb_addr,
  input  logic [7:0]        fb_rdata,
  output logic              HSYNC,
  output logic              VSYNC,
  output logic [7:0]        RGB,
  output logic              frame_done,
  output logic [15:0]       frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS    = HW'(H_VISIBLE);
  localparam logic [VW-1:0] V_VIS    = VW'(V_VISIBLE);
  localparam logic [HW-1:0] HS_FIRST = HW'(H_VISIBLE + H_FP);
  localparam logic [HW-1:0] HS_LAST  = HW'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam logic [VW-1:0] VS_FIRST = VW'(V_VISIBLE + V_FP);
  localparam logic [VW-1:0] VS_LAST  = VW'(V_VISIBLE + V_FP + V_SYNC - 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state, state_nxt;
  logic              toggle;
  logic [HW-1:0]     h_cnt;
  logic [VW-1:0]     v_cnt;
  logic [ADDR_W-1:0] addr_ptr, addr_hold, cur_ptr;
  logic              visible_d, hs_n_d, vs_n_d;
  logic              tick, run_tick, visible, hs_n, vs_n, frame_end;

  assign tick      = toggle;
  // The tick that leaves IDLE already paints pixel (0,0) straight from cfg_base.
  assign run_tick  = tick && ((state == RUN) || enable);
  assign visible   = (h_cnt < H_VIS) && (v_cnt < V_VIS);
  assign hs_n      = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
  assign vs_n      = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));
  assign frame_end = tick && (state == RUN) && (h_cnt == H_LAST) && (v_cnt == V_LAST);
  assign cur_ptr   = (state == IDLE) ? cfg_base : addr_ptr;

  assign fb_rd_en   = run_tick && visible;
  assign fb_addr    = fb_rd_en ? cur_ptr : addr_hold;
  assign frame_done = frame_end;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of the order the blocks are evaluated.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) state <= IDLE;
    else          state <= state_nxt;
  end

  // NOTE: the default assignment first guarantees no latch on any path.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (tick && enable)        state_nxt = RUN;
      RUN:     if (frame_end && !enable)  state_nxt = IDLE;
      default:                            state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      toggle      <= 1'b0;
      h_cnt       <= '0;
      v_cnt       <= '0;
      addr_ptr    <= '0;
      addr_hold   <= '0;
      frame_count <= '0;
    end else begin
      toggle <= ~toggle;
      if (run_tick) begin
        if (h_cnt == H_LAST) begin
          h_cnt <= '0;
          v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
        end else begin
          h_cnt <= h_cnt + 1'b1;
        end
        // Rebase once per frame; mid-frame cfg_base changes wait for this point.
        if (frame_end)    addr_ptr <= cfg_base;
        else if (visible) addr_ptr <= cur_ptr + 1'b1;
      end
      if (fb_rd_en)  addr_hold   <= cur_ptr;
      if (frame_end) frame_count <= frame_count + 16'd1;
    end
  end

  // Stage 1 captures on the tick; stage 2 fires on the following non-tick edge,
  // when fb_rdata for that tick's read is present.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      visible_d <= 1'b0;
      hs_n_d    <= 1'b1;
      vs_n_d    <= 1'b1;
      RGB       <= 8'h00;
      HSYNC     <= 1'b1;
      VSYNC     <= 1'b1;
    end else if (tick) begin
      visible_d <= run_tick && visible;
      hs_n_d    <= run_tick ? hs_n : 1'b1;
      vs_n_d    <= run_tick ? vs_n : 1'b1;
    end else begin
      RGB   <= visible_d ? fb_rdata : 8'h00;
      HSYNC <= hs_n_d;
      VSYNC <= vs_n_d;
    end
  end

endmodule

// File: tb/tb_vga_timing_sequencer.sv
// Directed bench for vga_timing_sequencer on a shrunken 8x6 raster (4x3 visible)
// so several frames fit in a short run; expected values are hand-computed.
`timescale 1ns/1ps
module tb_vga_timing_sequencer;

  localparam int AW = 8;

  logic          HCLK = 1'b0;
  logic          HRESETn = 1'b0;
  logic          enable = 1'b1;
  logic [AW-1:0] cfg_base = 8'h10;
  logic          fb_rd_en;
  logic [AW-1:0] fb_addr;
  logic [7:0]    fb_rdata = 8'h00;
  logic          HSYNC, VSYNC, frame_done;
  logic [7:0]    RGB;
  logic [15:0]   frame_count;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  vga_timing_sequencer #(
    .H_VISIBLE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_VISIBLE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .ADDR_W(AW)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .enable(enable), .cfg_base(cfg_base),
    .fb_rd_en(fb_rd_en), .fb_addr(fb_addr), .fb_rdata(fb_rdata),
    .HSYNC(HSYNC), .VSYNC(VSYNC), .RGB(RGB),
    .frame_done(frame_done), .frame_count(frame_count)
  );

  always #5 HCLK = ~HCLK;

  // Frame buffer: data = addr + 0x40, one HCLK after the strobe; 0xFF when not read.
  always @(posedge HCLK) fb_rdata <= fb_rd_en ? fb_addr + 8'h40 : 8'hFF;

  typedef struct {
    int          cyc;
    logic        en;
    logic [7:0]  cfg;
    logic        rd;
    logic [7:0]  addr;
    logic        hs;
    logic        vs;
    logic [7:0]  rgb;
    logic        fd;
    logic [15:0] fc;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(int c, logic en, logic [7:0] cfg, logic rd, logic [7:0] addr,
                              logic hs, logic vs, logic [7:0] rgb, logic fd, logic [15:0] fc);
    vec_t v;
    v = '{c, en, cfg, rd, addr, hs, vs, rgb, fd, fc};
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [35:0] act, input logic [35:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [35:0] outs();
    return {fb_rd_en, fb_addr, HSYNC, VSYNC, RGB, frame_done, frame_count};
  endfunction

  initial begin
    int       first_rd;
    int       fd_cyc;
    logic [7:0] first_addr;

    // cycle, enable, cfg_base | rd_en, addr, HSYNC, VSYNC, RGB, frame_done, frame_count
    add(  1, 1, 8'h10, 0, 8'h00, 1, 1, 8'h00, 0, 0);
    add(  2, 1, 8'h10, 1, 8'h10, 1, 1, 8'h00, 0, 0);
    add(  3, 1, 8'h10, 0, 8'h10, 1, 1, 8'h00, 0, 0);
    add(  4, 1, 8'h10, 1, 8'h11, 1, 1, 8'h50, 0, 0);
    add(  5, 1, 8'h10, 0, 8'h11, 1, 1, 8'h50, 0, 0);
    add(  8, 1, 8'h10, 1, 8'h13, 1, 1, 8'h52, 0, 0);
    add( 10, 1, 8'h10, 0, 8'h13, 1, 1, 8'h53, 0, 0);
    add( 12, 1, 8'h10, 0, 8'h13, 1, 1, 8'h00, 0, 0);
    add( 13, 1, 8'h10, 0, 8'h13, 1, 1, 8'h00, 0, 0);
    add( 14, 1, 8'h10, 0, 8'h13, 0, 1, 8'h00, 0, 0);
    add( 17, 1, 8'h10, 0, 8'h13, 0, 1, 8'h00, 0, 0);
    add( 18, 1, 8'h10, 1, 8'h14, 1, 1, 8'h00, 0, 0);
    add( 20, 1, 8'h10, 1, 8'h15, 1, 1, 8'h54, 0, 0);
    add( 30, 1, 8'hFE, 0, 8'h17, 0, 1, 8'h00, 0, 0);
    add( 34, 1, 8'hFE, 1, 8'h18, 1, 1, 8'h00, 0, 0);
    add( 36, 1, 8'hFE, 1, 8'h19, 1, 1, 8'h58, 0, 0);
    add( 40, 1, 8'hFE, 1, 8'h1B, 1, 1, 8'h5A, 0, 0);
    add( 42, 1, 8'hFE, 0, 8'h1B, 1, 1, 8'h5B, 0, 0);
    add( 50, 1, 8'hFE, 0, 8'h1B, 1, 1, 8'h00, 0, 0);
    add( 67, 1, 8'hFE, 0, 8'h1B, 1, 1, 8'h00, 0, 0);
    add( 68, 1, 8'hFE, 0, 8'h1B, 1, 0, 8'h00, 0, 0);
    add( 83, 1, 8'hFE, 0, 8'h1B, 1, 0, 8'h00, 0, 0);
    add( 84, 1, 8'hFE, 0, 8'h1B, 1, 1, 8'h00, 0, 0);
    add( 95, 1, 8'hFE, 0, 8'h1B, 0, 1, 8'h00, 0, 0);
    add( 96, 1, 8'hFE, 0, 8'h1B, 0, 1, 8'h00, 1, 0);
    add( 97, 1, 8'hFE, 0, 8'h1B, 0, 1, 8'h00, 0, 1);
    add( 98, 1, 8'hFE, 1, 8'hFE, 1, 1, 8'h00, 0, 1);
    add(100, 1, 8'hFE, 1, 8'hFF, 1, 1, 8'h3E, 0, 1);
    add(102, 1, 8'hFE, 1, 8'h00, 1, 1, 8'h3F, 0, 1);
    add(104, 1, 8'hFE, 1, 8'h01, 1, 1, 8'h40, 0, 1);
    add(120, 0, 8'hFE, 1, 8'h05, 1, 1, 8'h44, 0, 1);
    add(130, 0, 8'hFE, 1, 8'h06, 1, 1, 8'h00, 0, 1);
    add(136, 0, 8'hFE, 1, 8'h09, 1, 1, 8'h48, 0, 1);
    add(138, 0, 8'hFE, 0, 8'h09, 1, 1, 8'h49, 0, 1);
    add(192, 0, 8'hFE, 0, 8'h09, 0, 1, 8'h00, 1, 1);
    add(193, 0, 8'hFE, 0, 8'h09, 0, 1, 8'h00, 0, 2);
    add(194, 0, 8'hFE, 0, 8'h09, 1, 1, 8'h00, 0, 2);
    add(196, 0, 8'hFE, 0, 8'h09, 1, 1, 8'h00, 0, 2);
    add(200, 0, 8'hFE, 0, 8'h09, 1, 1, 8'h00, 0, 2);
    add(201, 1, 8'h30, 0, 8'h09, 1, 1, 8'h00, 0, 2);
    add(202, 1, 8'h30, 1, 8'h30, 1, 1, 8'h00, 0, 2);
    add(204, 1, 8'h30, 1, 8'h31, 1, 1, 8'h70, 0, 2);
    add(206, 1, 8'h30, 1, 8'h32, 1, 1, 8'h71, 0, 2);

    // Held in reset with enable high: everything at its reset value.
    repeat (3) @(negedge HCLK);
    #1 check("reset values", outs(), {1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 16'h0000});

    @(negedge HCLK);
    HRESETn = 1'b1;
    cyc = 1;
    foreach (vecs[i]) begin
      while (cyc < vecs[i].cyc) begin
        @(negedge HCLK);
        cyc++;
      end
      enable   = vecs[i].en;
      cfg_base = vecs[i].cfg;
      #1;
      check($sformatf("vector cyc %0d {rd,addr,hs,vs,rgb,fd,fc}", vecs[i].cyc), outs(),
            {vecs[i].rd, vecs[i].addr, vecs[i].hs, vecs[i].vs, vecs[i].rgb, vecs[i].fd, vecs[i].fc});
    end

    // Asynchronous reset between clock edges, in the middle of a visible read.
    #2 HRESETn = 1'b0;
    #1 check("async reset mid-frame", outs(), {1'b0, 8'h00, 1'b1, 1'b1, 8'h00, 1'b0, 16'h0000});

    // Restart from reset with a new base; bounded wait for the first frame_done.
    enable   = 1'b1;
    cfg_base = 8'h80;
    @(negedge HCLK);
    HRESETn    = 1'b1;
    first_rd   = -1;
    first_addr = 8'h00;
    fd_cyc     = -1;
    for (int c = 1; c <= 300 && fd_cyc < 0; c++) begin
      if (c > 1) @(negedge HCLK);
      #1;
      if (fb_rd_en && first_rd < 0) begin
        first_rd   = c;
        first_addr = fb_addr;
      end
      if (frame_done) fd_cyc = c;
    end
    check("restart first read cycle", 36'(first_rd), 36'd2);
    check("restart first read addr", 36'(first_addr), 36'h80);
    check("restart frame_done cycle (-1 = timeout)", 36'(fd_cyc), 36'd96);
    #1 check("restart frame_count at frame end", 36'(frame_count), 36'd0);
    @(negedge HCLK);
    #1 check("restart frame_count after frame end", 36'(frame_count), 36'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
